// File: rtl/nibble_pkg.sv
// ============================================================================
// Module   : nibble_pkg
// Purpose  : Shared types for the nibble-serial adder slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_pkg;

  localparam int NIB_W = 4;

  typedef logic [NIB_W-1:0] nib_t;

  typedef struct packed {
    nib_t sum;
    logic cout;
    logic last;
  } nib_out_t;

endpackage

`default_nettype wire

// File: rtl/nibble_add4.sv
// ============================================================================
// Module   : nibble_add4
// Purpose  : Combinational 4-bit ripple-carry adder built from full-adder cells.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_add4
  import nibble_pkg::*;
(
  input  nib_t a_i,
  input  nib_t b_i,
  input  logic cin_i,
  output nib_t sum_o,
  output logic cout_o
);

  always_comb begin
    logic c;
    c     = cin_i;
    sum_o = '0;
    for (int k = 0; k < NIB_W; k++) begin
      sum_o[k] = a_i[k] ^ b_i[k] ^ c;
      c        = (a_i[k] & b_i[k]) | (c & (a_i[k] ^ b_i[k]));
    end
    cout_o = c;
  end

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module   : nibble_serial_adder
// Purpose  : Multi-precision adder fed LS-nibble first, with carry chaining and
//            a one-deep valid/ready output register.
//            Optional NIBBLE_SERIAL_ADDER_OVF_EN adds a signed-overflow output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder
  import nibble_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       in_cin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sum,
  output logic       out_cout,
  output logic       out_last
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic       out_ovf
`endif
);

  localparam int              CNT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;
  nib_out_t         out_q, out_d;

  logic w_accept;
  logic w_first;
  logic w_last;
  logic w_cin;
  logic w_cout;
  nib_t w_sum;

  assign in_ready = !valid_q || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_first  = (cnt_q == '0);
  assign w_last   = (cnt_q == LAST_CNT);
  // A new operand always reseeds from in_cin, so a stale carry never leaks in.
  assign w_cin    = w_first ? in_cin : carry_q;

  nibble_add4 u_add4 (
    .a_i    (in_a),
    .b_i    (in_b),
    .cin_i  (w_cin),
    .sum_o  (w_sum),
    .cout_o (w_cout)
  );

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    valid_d = valid_q;
    out_d   = out_q;
    if (w_accept) begin
      cnt_d      = w_last ? '0 : cnt_q + CNT_W'(1);
      carry_d    = w_cout;
      valid_d    = 1'b1;
      out_d.sum  = w_sum;
      out_d.cout = w_cout;
      out_d.last = w_last;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = out_q.sum;
  assign out_cout  = out_q.cout;
  assign out_last  = out_q.last;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  logic w_ovf;

  assign w_ovf = w_last && (in_a[3] == in_b[3]) && (w_sum[3] != in_a[3]);

  always_comb begin
    ovf_d = ovf_q;
    if (w_accept) begin
      ovf_d = w_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module   : tb_nibble_serial_adder
// Purpose  : Scoreboard bench for nibble_serial_adder (NIBBLES=4 and NIBBLES=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

  localparam int N = 4;

  typedef struct {
    logic [3:0] sum;
    logic       cout;
    logic       last;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_last;
  logic [3:0] in_a, in_b, out_sum;
  logic       in_valid1, in_ready1, in_cin1, out_valid1, out_ready1, out_cout1, out_last1;
  logic [3:0] in_a1, in_b1, out_sum1;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic       out_ovf, out_ovf1;
`endif

  exp_t q[$];
  exp_t q1[$];
  exp_t me, me1;
  int   errors = 0;
  int   checks = 0;
  bit   rand_rdy = 1'b0;

  logic       prev_stall;
  logic [3:0] prev_sum;
  logic       prev_cout, prev_last;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_last(out_last)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .out_cout(out_cout1), .out_last(out_last1)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    , .out_ovf(out_ovf1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: nibble k of a+b+cin and the carry out of the low (k+1) nibbles.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input int k, input int n);
    exp_t        e;
    logic [63:0] m, p;
    int          msb;
    m      = (64'd1 << (4 * (k + 1))) - 64'd1;
    p      = (a & m) + (b & m) + 64'(cin);
    msb    = 4 * n - 1;
    e.sum  = 4'(p >> (4 * k));
    e.cout = p[4 * (k + 1)];
    e.last = (k == n - 1);
    e.ovf  = e.last && (a[msb] == b[msb]) && (p[msb] != a[msb]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_sum", 32'(out_sum), 32'(prev_sum));
        check("hold_cout_last", 32'({out_cout, out_last}), 32'({prev_cout, prev_last}));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got sum %0h with empty scoreboard", out_sum);
        end else begin
          me = q.pop_front();
          check("sum", 32'(out_sum), 32'(me.sum));
          check("cout", 32'(out_cout), 32'(me.cout));
          check("last", 32'(out_last), 32'(me.last));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          check("ovf", 32'(out_ovf), 32'(me.ovf));
`endif
        end
      end
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output_n1: got sum %0h with empty scoreboard", out_sum1);
        end else begin
          me1 = q1.pop_front();
          check("n1_sum", 32'(out_sum1), 32'(me1.sum));
          check("n1_cout", 32'(out_cout1), 32'(me1.cout));
          check("n1_last", 32'(out_last1), 32'(me1.last));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          check("n1_ovf", 32'(out_ovf1), 32'(me1.ovf));
`endif
        end
      end
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_sum   = out_sum;
    prev_cout  = out_cout;
    prev_last  = out_last;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wait_accept();
    int   n;
    logic acc;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %0b for %0d cycles", in_ready, n);
    end
  endtask

  task automatic send_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input int nbeats, input int stall_beat, input bit gaps);
    exp_t e;
    for (int k = 0; k < nbeats; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_a     = 4'(a >> (4 * k));
      in_b     = 4'(b >> (4 * k));
      in_cin   = (k == 0) ? cin : 1'($urandom_range(0, 1));
      wait_accept();
      e = model(a, b, cin, k, N);
      q.push_back(e);
      if (k == stall_beat) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_sum_held", 32'(out_sum), 32'(e.sum));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_n1(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic acc;
    in_valid1 = 1'b1;
    in_a1     = a;
    in_b1     = b;
    in_cin1   = cin;
    @(negedge clk);
    acc = in_ready1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    if (acc) q1.push_back(model(64'(a), 64'(b), cin, 0, 1));
    else check("n1_in_ready", 32'(acc), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_cin1 = 1'b0; out_ready1 = 1'b1;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'({out_sum, out_cout, out_last}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    send_op(64'h1234, 64'h0FFF, 1'b0, N, -1, 1'b0);
    send_op(64'hFFFF, 64'h0001, 1'b0, N, -1, 1'b0);
    send_op(64'h7FFF, 64'h0001, 1'b0, N, -1, 1'b0);
    send_op(64'h0000, 64'h0000, 1'b1, N, -1, 1'b0);
    send_op(64'h0000, 64'h0000, 1'b0, N, -1, 1'b0);
    send_op(64'h1234, 64'h0FFF, 1'b0, N, 1, 1'b0);

    // Mid-operand reset: partial operand must vanish.
    send_op(64'hABCD, 64'h5678, 1'b1, 2, -1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    q1.delete();
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_outputs", 32'({out_sum, out_cout, out_last}), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send_op(64'h0001, 64'h0001, 1'b0, N, -1, 1'b0);

    send_n1(4'hF, 4'h1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      send_n1(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    end

    rand_rdy = 1'b1;
    for (int i = 0; i < 25; i++) begin
      send_op(64'($urandom_range(0, 16'hFFFF)), 64'($urandom_range(0, 16'hFFFF)),
              1'($urandom_range(0, 1)), N, -1, 1'b1);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    n = 0;
    while ((q.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_q", 32'(q.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
